// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with load, increment, relative branch and a return-address stack.
// State advances on the falling edge of Clock; Resetn is an asynchronous active-high reset.
module pc_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [WIDTH-1:0]           R,
    input  logic                       Rin,
    input  logic                       IncrPc,
    input  logic                       BrRel,
    input  logic                       Call,
    input  logic                       Ret,
    output logic [WIDTH-1:0]           Q,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Overflow,
    output logic                       Underflow
);
    localparam int DW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] q_inc;
    logic [DW-1:0]    depth_dec;
    logic             push;

    assign q_inc     = Q + WIDTH'(1);
    assign depth_dec = Depth - DW'(1);
    assign Empty     = Depth == '0;
    assign Full      = Depth == DW'(DEPTH);
    // Ret outranks Call, so a simultaneous Call never pushes
    assign push      = !Ret && Call && !Full;

    always_ff @(negedge Clock) begin
        if (push) stack[Depth[AW-1:0]] <= q_inc;
    end

    always_ff @(negedge Clock or posedge Resetn) begin
        if (Resetn) begin
            Q         <= RESET_ADDR;
            Depth     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (Ret) begin
            if (Empty) begin
                Underflow <= 1'b1;
            end else begin
                Q     <= stack[depth_dec[AW-1:0]];
                Depth <= depth_dec;
            end
        end else if (Call) begin
            Q <= R;
            if (Full) Overflow <= 1'b1;
            else Depth <= Depth + DW'(1);
        end else if (Rin) begin
            Q <= R;
        end else if (BrRel) begin
            Q <= q_inc + R;
        end else if (IncrPc) begin
            Q <= q_inc;
        end
    end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed plan plus random command streams against a queue-based PC model.
module tb_pc_stack_unit;
    localparam logic [4:0] RET = 5'b10000, CALL = 5'b01000, RIN = 5'b00100, BR = 5'b00010, INC = 5'b00001;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] r = '0;
    logic        rin = 1'b0, incr_pc = 1'b0, br_rel = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] q;
    logic [2:0]  depth;
    logic        empty, full, ovf, unf;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_q = '0;
    logic [15:0] m_stk [$];
    logic        m_ovf = 1'b0, m_unf = 1'b0;

    pc_stack_unit #(.WIDTH(16), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
        .Clock(clk), .Resetn(rst), .R(r), .Rin(rin), .IncrPc(incr_pc), .BrRel(br_rel),
        .Call(call), .Ret(ret), .Q(q), .Depth(depth), .Empty(empty), .Full(full),
        .Overflow(ovf), .Underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".depth"}, 32'(depth), 32'(m_stk.size()));
        check({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(m_stk.size() == DEPTH));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(unf), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_q = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic step(input logic [4:0] cmd, input logic [15:0] val);
        @(posedge clk);
        {ret, call, rin, br_rel, incr_pc} = cmd;
        r = val;
        @(negedge clk);
        #1;
        if (cmd[4]) begin
            if (m_stk.size() > 0) m_q = m_stk.pop_back();
            else m_unf = 1'b1;
        end else if (cmd[3]) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_q + 16'd1);
            else m_ovf = 1'b1;
            m_q = val;
        end else if (cmd[2]) m_q = val;
        else if (cmd[1]) m_q = m_q + 16'd1 + val;
        else if (cmd[0]) m_q = m_q + 16'd1;
        check_all("step");
    endtask

    task automatic areset();
        {ret, call, rin, br_rel, incr_pc} = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("areset.q", 32'(q), 32'h0);
        check("areset.depth", 32'(depth), 32'h0);
        check("areset.flags", {30'd0, ovf, unf}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #12;
        check_all("reset");
        check("reset.empty", 32'(empty), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step(INC, 16'h0);
        check("tp.inc3", 32'(q), 32'h3);
        step(RIN, 16'hFFFF);
        step(INC, 16'h0);
        check("tp.wrap", 32'(q), 32'h0);
        step(RIN, 16'h0010);
        step(BR, 16'hFFFC);
        check("tp.brrel", 32'(q), 32'h000D);
        step(RIN, 16'h0005);
        step(CALL, 16'h0100);
        step(CALL, 16'h0200);
        check("tp.nest_depth", 32'(depth), 32'h2);
        step(RET, 16'h0);
        check("tp.ret1", 32'(q), 32'h0101);
        step(RET, 16'h0);
        check("tp.ret2", 32'(q), 32'h0006);
        step(RIN, 16'h0020);
        for (int i = 0; i < 5; i++) step(CALL, 16'h1000 + 16'(i));
        check("tp.ovf_q", 32'(q), 32'h1004);
        check("tp.ovf_flags", {29'd0, depth, full, ovf}, {29'd4, 1'b1, 1'b1});
        step(RET, 16'h0);
        check("tp.lifo0", 32'(q), 32'h1003);
        step(RET, 16'h0);
        check("tp.lifo1", 32'(q), 32'h1002);
        step(RET, 16'h0);
        check("tp.lifo2", 32'(q), 32'h1001);
        step(RET, 16'h0);
        check("tp.lifo3", 32'(q), 32'h0021);
        check("tp.ovf_sticky", 32'(ovf), 32'h1);
        step(RIN, 16'h0007);
        step(RET, 16'h0);
        check("tp.unf", {15'd0, q, unf}, {15'd0, 16'h0007, 1'b1});
        step(CALL, 16'h0300);
        step(RET | CALL | INC, 16'h0500);
        check("tp.prio_q", 32'(q), 32'h0008);
        check("tp.prio_depth", 32'(depth), 32'h0);
        repeat (3) step(CALL, 16'h0400);
        step(RIN, 16'h0042);
        areset();
        step(INC, 16'h0);
        check("tp.after_reset", 32'(q), 32'h1);
        for (int i = 0; i < 400; i++) begin
            logic [4:0] cmd;
            cmd = 5'($urandom);
            if ($urandom_range(0, 2) != 0) cmd[4] = 1'b0;
            step(cmd, 16'($urandom));
            if ($urandom_range(0, 60) == 0) areset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the processor datapath: a WIDTH-bit PC register with load, increment, PC-relative branch, and a hardware return-address stack of DEPTH entries for call/return. It replaces the fixed 16-bit load/increment PC. It sits between the control unit, which drives the one-hot-style command strobes, and the instruction-memory address bus, which is driven by Q.

## Interface
Parameters:
- WIDTH, 16, PC and data width in bits (≥ 4)
- DEPTH, 4, return-stack entries (≥ 2)
- RESET_ADDR, 0, value loaded into Q on reset

Ports:
- Clock  in  1  system clock; all state updates on the falling edge
- Resetn  in  1  asynchronous, active-high reset (1 = reset)
- R  in  WIDTH  load/call target, or signed branch offset for BrRel
- Rin  in  1  load Q <= R
- IncrPc  in  1  Q <= Q + 1
- BrRel  in  1  Q <= Q + 1 + R (R two's complement)
- Call  in  1  push Q + 1, then Q <= R
- Ret  in  1  pop, then Q <= top of stack
- Q  out  WIDTH  current PC
- Depth  out  $clog2(DEPTH+1)  number of valid stack entries
- Empty  out  1  Depth == 0 (combinational)
- Full  out  1  Depth == DEPTH (combinational)
- Overflow  out  1  sticky: Call issued while Full
- Underflow  out  1  sticky: Ret issued while Empty

## Operation
- Resetn = 1 (asynchronous, any time): Q = RESET_ADDR, Depth = 0, Overflow = 0, Underflow = 0; stack contents are don't-care.
- At each negedge Clock with Resetn = 0, exactly one action executes, chosen by fixed priority: Ret > Call > Rin > BrRel > IncrPc > hold. Lower-priority strobes asserted in the same cycle are ignored, with no side effects.
- Ret, not Empty: Q <= stack[Depth-1]; Depth <= Depth-1.
- Ret, Empty: Q holds; Depth stays 0; Underflow <= 1.
- Call, not Full: stack[Depth] <= Q+1; Depth <= Depth+1; Q <= R.
- Call, Full: Q <= R (the jump still happens); the push is dropped; the stack is unchanged; Overflow <= 1.
- Rin: Q <= R. IncrPc: Q <= Q+1. BrRel: Q <= Q+1+R.
- All PC arithmetic is modulo 2^WIDTH. There is no carry out, so the wrap from all-ones to 0 is silent and legal.
- Stack is LIFO, indexed by Depth. There is no separate pointer register.
- Overflow and Underflow are cleared only by reset.

## Timing
- Single-cycle: Q, Depth, and the flags change 0 clock cycles after the active falling edge and are stable until the next falling edge.
- Commands are sampled at the falling edge. The control unit changes strobes on the rising edge, which gives a half-cycle setup.
- Empty and Full are combinational from Depth, so they are valid in the same half-cycle as Depth.
- Reset mid-operation: asserting Resetn between edges forces the reset values immediately. The first action after deassertion takes place at the next falling edge at which Resetn = 0.
- Back-to-back Call/Ret on consecutive edges is fully supported; the stack read uses the registered Depth.
- Call+Ret in the same cycle: Ret executes and Call is ignored, so no push happens.

## Test plan
- Reset and increment: Resetn pulse → Q = 0, Depth = 0, Empty = 1; then 3 cycles of IncrPc → Q = 3.
- Wrap and branch: Rin with R = 16'hFFFF, then IncrPc → Q = 0. From Q = 16'h0010, BrRel with R = 16'hFFFC (-4) → Q = 16'h000D.
- Nested call/return: at Q = 5, Call R = 16'h0100 → Q = 16'h0100, Depth = 1. Call R = 16'h0200 → Depth = 2. Ret → Q = 16'h0101, Depth = 1. Ret → Q = 6, Empty = 1.
- Overflow: DEPTH = 4, five Calls in a row → fifth sets Q = R, Depth = 4, Full = 1, Overflow = 1. Four Rets return the first four return addresses in LIFO order. Overflow stays 1.
- Underflow and priority: Ret while Empty at Q = 7 → Q = 7, Underflow = 1. Ret+Call+IncrPc in the same cycle with Depth = 1 → pop occurs, Depth = 0, no push, no increment.
- Asynchronous reset mid-stream: with Depth = 3 and Q = 16'h0042, raise Resetn between edges → Q = 0, Depth = 0, and both flags 0 before the next edge. After release, IncrPc → Q = 1.
